bitstream_frame_ctrl: RTL

- Receive-side sequencer that sits beside the bit-to-byte deserializer; both receive the same serial bit stream.
- In HUNT, it watches raw bits for the sync word and holds the deserializer in reset. It releases the reset so that the deserializer's first captured bit is the first bit after sync.
- After sync, it parses the assembled bytes as a frame: LEN, then LEN payload bytes, then an XOR checksum byte.
- It forwards the payload with SOF/EOF markers and reports per-frame ok/error status to the framing layer.

---
 rtl/bitstream_frame_pkg.sv | 16 +
 rtl/bitstream_frame_ctrl_sync_hunter.sv | 40 ++++
 rtl/bitstream_frame_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bitstream_frame_pkg.sv
// Shared types and constants for the receive-side bitstream frame controller.
package bitstream_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/bitstream_frame_ctrl_sync_hunter.sv
// Sliding-window sync detector on the raw LSB-first bit stream.
module sync_hunter
    import bitstream_frame_pkg::*;
#(
    parameter int                BYTE_W    = 8,
    parameter logic [BYTE_W-1:0] SYNC_WORD = 8'hA5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_bit_in,
    input  logic i_bit_valid,
    output logic o_match
);

    localparam int FW = $clog2(BYTE_W + 1);

    logic [BYTE_W-1:0] r_sr;
    logic [FW-1:0]     r_fill;
    logic [BYTE_W-1:0] w_sr_next;

    assign w_sr_next = {i_bit_in, r_sr[BYTE_W-1:1]};
    assign o_match   = i_bit_valid && (r_fill >= FW'(BYTE_W - 1)) && (w_sr_next == SYNC_WORD);

    // A match also restarts the window so no bits of the sync word are reused.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr   <= '0;
            r_fill <= '0;
        end else if (i_clr || o_match) begin
            r_sr   <= '0;
            r_fill <= '0;
        end else if (i_bit_valid) begin
            r_sr <= w_sr_next;
            if (r_fill != FW'(BYTE_W))
                r_fill <= r_fill + 1'b1;
        end
    end

endmodule

// File: rtl/bitstream_frame_ctrl.sv
// Frame sequencer: hunts for sync, then parses LEN / payload / XOR checksum bytes.
module bitstream_frame_ctrl
    import bitstream_frame_pkg::*;
#(
    parameter int                BYTE_W    = 8,
    parameter logic [BYTE_W-1:0] SYNC_WORD = 8'hA5,
    parameter int                MAX_LEN   = 64,
    parameter int                TIMEOUT   = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_bit_in,
    input  logic              i_bit_valid,
    input  logic [BYTE_W-1:0] i_byte_in,
    input  logic              i_byte_valid,
    output logic              o_deser_rst,
    output logic [BYTE_W-1:0] o_pay_data,
    output logic              o_pay_valid,
    output logic              o_pay_sof,
    output logic              o_pay_eof,
    output logic              o_frame_ok,
    output logic              o_frame_err,
    output logic [1:0]        o_err_code,
    output logic              o_in_frame
);

    localparam int IW = $clog2(TIMEOUT + 1);

    state_t            r_state;
    logic [BYTE_W-1:0] r_len;
    logic [BYTE_W-1:0] r_cnt;
    logic [BYTE_W-1:0] r_acc;
    logic [IW-1:0]     r_idle;
    logic              r_deser_rst;
    logic [BYTE_W-1:0] r_pay_data;
    logic              r_pay_valid;
    logic              r_pay_sof;
    logic              r_pay_eof;
    logic              r_frame_ok;
    logic              r_frame_err;
    logic [1:0]        r_err_code;
    logic              r_in_frame;

    logic w_match;
    logic w_hunt_clr;
    logic w_len_bad;
    logic w_last;
    logic w_timeout;
    logic w_to_hunt;

    // The hunter only runs while actually hunting, so it always restarts empty.
    assign w_hunt_clr = !i_enable || (r_state != HUNT);

    sync_hunter #(
        .BYTE_W    (BYTE_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_hunter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_hunt_clr),
        .i_bit_in    (i_bit_in),
        .i_bit_valid (i_bit_valid),
        .o_match     (w_match)
    );

    assign w_len_bad = (i_byte_in == '0) || (i_byte_in > BYTE_W'(MAX_LEN));
    assign w_last    = (r_cnt == r_len - 1'b1);
    assign w_timeout = !i_bit_valid && (r_idle == IW'(TIMEOUT - 1));

    // A byte arriving in the same cycle as the timeout takes precedence.
    assign w_to_hunt = !i_enable ||
                       ((r_state != HUNT) &&
                        (i_byte_valid ? ((r_state == CHECK) || ((r_state == LEN) && w_len_bad))
                                      : w_timeout));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= HUNT;
            r_len       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_idle      <= '0;
            r_deser_rst <= 1'b1;
            r_pay_data  <= '0;
            r_pay_valid <= 1'b0;
            r_pay_sof   <= 1'b0;
            r_pay_eof   <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_in_frame  <= 1'b0;
        end else begin
            r_pay_valid <= 1'b0;
            r_pay_sof   <= 1'b0;
            r_pay_eof   <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;

            if (i_enable) begin
                if (r_state == HUNT) begin
                    if (w_match) begin
                        r_state     <= LEN;
                        r_deser_rst <= 1'b0;
                        r_in_frame  <= 1'b1;
                    end
                end else begin
                    r_idle <= i_bit_valid ? '0 : r_idle + 1'b1;
                    if (i_byte_valid) begin
                        case (r_state)
                            LEN: begin
                                r_len <= i_byte_in;
                                r_acc <= i_byte_in;
                                r_cnt <= '0;
                                if (w_len_bad) begin
                                    r_frame_err <= 1'b1;
                                    r_err_code  <= ERR_LEN;
                                end else begin
                                    r_state <= PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                r_pay_data  <= i_byte_in;
                                r_pay_valid <= 1'b1;
                                r_pay_sof   <= (r_cnt == '0);
                                r_pay_eof   <= w_last;
                                r_acc       <= r_acc ^ i_byte_in;
                                r_cnt       <= r_cnt + 1'b1;
                                if (w_last)
                                    r_state <= CHECK;
                            end
                            CHECK: begin
                                if (i_byte_in == r_acc) begin
                                    r_frame_ok <= 1'b1;
                                end else begin
                                    r_frame_err <= 1'b1;
                                    r_err_code  <= ERR_CSUM;
                                end
                            end
                            default: ;
                        endcase
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_err_code  <= ERR_TMO;
                    end
                end
            end

            // Returning to HUNT overrides whatever the state logic above chose.
            if (w_to_hunt) begin
                r_state     <= HUNT;
                r_deser_rst <= 1'b1;
                r_in_frame  <= 1'b0;
                r_cnt       <= '0;
                r_acc       <= '0;
                r_idle      <= '0;
            end
        end
    end

    assign o_deser_rst = r_deser_rst;
    assign o_pay_data  = r_pay_data;
    assign o_pay_valid = r_pay_valid;
    assign o_pay_sof   = r_pay_sof;
    assign o_pay_eof   = r_pay_eof;
    assign o_frame_ok  = r_frame_ok;
    assign o_frame_err = r_frame_err;
    assign o_err_code  = r_err_code;
    assign o_in_frame  = r_in_frame;

endmodule
